seg7_serial_tx: RTL and testbench

Parallel-to-serial transmitter for the board's seven-segment shift-register chain. It sits directly downstream of the segment-pattern decoder: it accepts one 64-bit pattern frame per valid/ready handshake and clocks the frame out MSB-first on the SEGLED_CLK/SEGLED_DO pins. It blanks the display through SEGLED_PEN while shifting and drives SEGLED_CLR from reset. It replaces free-running serialisation with a framed, handshaked, divider-timed transfer.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_serial_tx_if.sv | 34 +++
 rtl/seg7_half_tick.sv | 44 ++++
 rtl/seg7_serial_tx.sv | 128 ++++++++++++
 tb/tb_seg7_serial_tx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared types and default constants for the seven-segment chain
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int SEG7_FRAME_W = 64;
  localparam int SEG7_CLK_DIV = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seg7_tx_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_serial_tx_if.sv
// ============================================================================
// seg7_serial_tx_if : frame handshake plus seven-segment pin bundle
// Revision : 1.0
// ============================================================================
`default_nettype none

interface seg7_serial_tx_if
  import seg7_pkg::*;
#(
  parameter int WIDTH = SEG7_FRAME_W
);

  logic [WIDTH-1:0] pdata;
  logic             valid;
  logic             ready;
  logic             done;
  logic             seg_clk;
  logic             seg_do;
  logic             seg_pen;
  logic             seg_clr;

  modport master (
    output pdata, valid,
    input  ready, done, seg_clk, seg_do, seg_pen, seg_clr
  );

  modport slave (
    input  pdata, valid,
    output ready, done, seg_clk, seg_do, seg_pen, seg_clr
  );

endinterface

`default_nettype wire

// File: rtl/seg7_half_tick.sv
// ============================================================================
// seg7_half_tick : CLK_DIV prescaler, one-cycle tick on each half-period wrap
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_half_tick
  import seg7_pkg::*;
#(
  parameter int CLK_DIV = SEG7_CLK_DIV
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en_i,
  input  wire logic clr_i,
  output logic      tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seg7_serial_tx.sv
// ============================================================================
// seg7_serial_tx : handshaked, divider-timed MSB-first frame serialiser
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_serial_tx
  import seg7_pkg::*;
#(
  parameter int WIDTH   = SEG7_FRAME_W,
  parameter int CLK_DIV = SEG7_CLK_DIV
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  seg7_serial_tx_if.slave  bus
);

  localparam int BW = $clog2(WIDTH);

  seg7_tx_state_t   state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             seg_clk_q, seg_clk_d;
  logic             seg_pen_q, seg_pen_d;
  logic             done_q, done_d;
  logic             seg_clr_q;
  logic             tick;
  logic             accept;
  logic             fall;
  logic             last;

  seg7_half_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_half_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == SHIFT),
    .clr_i  (state_q != SHIFT),
    .tick_o (tick)
  );

  assign accept = (state_q == IDLE) && rst_n && bus.valid;
  assign fall   = tick && seg_clk_q;
  assign last   = fall && (bitcnt_q == BW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The final fall also shifts, leaving the register all-zero so seg_do idles low.
  always_comb begin
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    seg_clk_d = seg_clk_q;
    seg_pen_d = seg_pen_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d   = bus.pdata;
          bitcnt_d  = '0;
          seg_clk_d = 1'b0;
          seg_pen_d = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) seg_clk_d = ~seg_clk_q;
        if (fall) begin
          shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
          bitcnt_d = last ? '0 : bitcnt_q + 1'b1;
        end
        if (last) begin
          seg_clk_d = 1'b0;
          seg_pen_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      DONE: begin
        seg_clk_d = 1'b0;
        seg_pen_d = 1'b1;
        bitcnt_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      seg_clk_q <= 1'b0;
      seg_pen_q <= 1'b1;
      done_q    <= 1'b0;
      seg_clr_q <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      seg_clk_q <= seg_clk_d;
      seg_pen_q <= seg_pen_d;
      done_q    <= done_d;
      seg_clr_q <= 1'b1;
    end
  end

  assign bus.ready   = (state_q == IDLE) && rst_n;
  assign bus.done    = done_q;
  assign bus.seg_clk = seg_clk_q;
  assign bus.seg_do  = shreg_q[WIDTH-1];
  assign bus.seg_pen = seg_pen_q;
  assign bus.seg_clr = seg_clr_q;

endmodule

`default_nettype wire

// File: tb/tb_seg7_serial_tx.sv
// ============================================================================
// tb_seg7_serial_tx : table-driven frame checks plus reset-abort and CLK_DIV=1
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_serial_tx;

  localparam int W  = 64;
  localparam int C2 = 2;

  typedef struct {
    logic [63:0] pdata;
    int          mode;       // 0 single pulse, 1 valid held, 2 random valid/pdata
    logic [63:0] exp_stream;
    int          exp_lat;
    int          exp_rises;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg7_serial_tx_if #(.WIDTH(W)) b2 ();
  seg7_serial_tx_if #(.WIDTH(W)) b1 ();

  seg7_serial_tx #(.WIDTH(W), .CLK_DIV(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b2.slave)
  );

  seg7_serial_tx #(.WIDTH(W), .CLK_DIV(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Offers one frame to the CLK_DIV=2 instance and observes it at negedges until done.
  task automatic run_frame(input logic [63:0] d, input int mode, input int abort_rises,
                           output logic [63:0] stream, output int lat, output int rises,
                           output int pen_bad, output int rdy_bad, output int stab_bad,
                           output int acc_cyc);
    int   guard;
    int   held;
    int   since_rise;
    logic prev_clk;
    logic prev_do;
    bit   busy;
    guard = 0;
    @(negedge clk);
    while (!b2.ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 64'(guard < 1000), 64'd1);
    b2.pdata = d;
    b2.valid = 1'b1;
    acc_cyc  = cyc;
    stream = '0; lat = 0; rises = 0; pen_bad = 0; rdy_bad = 0; stab_bad = 0;
    held = 0; since_rise = 1000; prev_clk = 1'b0; prev_do = 1'b0; busy = 1'b1;
    while (busy && lat < 1000) begin
      @(negedge clk);
      lat++;
      since_rise++;
      if (mode == 0) b2.valid = 1'b0;
      else if (mode == 2) begin
        b2.valid = 1'($urandom_range(0, 1));
        b2.pdata = {$urandom, $urandom};
      end
      if (b2.done) begin
        busy = 1'b0;
      end else begin
        if (b2.ready) rdy_bad++;
        if (b2.seg_pen) pen_bad++;
        if (b2.seg_do != prev_do) begin
          if (lat > 1 && since_rise < C2) stab_bad++;
          held = 1;
        end else begin
          held++;
        end
        if (b2.seg_clk && !prev_clk) begin
          rises++;
          stream = {stream[62:0], b2.seg_do};
          if (held - 1 < C2) stab_bad++;
          since_rise = 0;
        end
        prev_clk = b2.seg_clk;
        prev_do  = b2.seg_do;
        if (abort_rises > 0 && rises == abort_rises) busy = 1'b0;
      end
    end
  endtask

  vec_t        tv[5];
  logic [63:0] stream;
  int          lat, rises, pen_bad, rdy_bad, stab_bad, acc_cyc, prev_acc;

  initial begin
    tv[0] = '{64'h8000_0000_0000_0001, 0, 64'h8000_0000_0000_0001, 257, 64};
    tv[1] = '{64'hA5A5_A5A5_A5A5_A5A5, 1, 64'hA5A5_A5A5_A5A5_A5A5, 257, 64};
    tv[2] = '{64'h0F0F_0F0F_0F0F_0F0F, 1, 64'h0F0F_0F0F_0F0F_0F0F, 257, 64};
    tv[3] = '{64'h1234_5678_9ABC_DEF0, 2, 64'h1234_5678_9ABC_DEF0, 257, 64};
    tv[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFF, 257, 64};

    b2.valid = 1'b0; b2.pdata = '0;
    b1.valid = 1'b0; b1.pdata = '0;
    prev_acc = 0;

    // Reset state, with valid offered to show it is ignored in reset
    rst_n = 1'b0;
    b2.valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_seg_clr", 64'(b2.seg_clr), 64'd0);
    chk("rst_seg_pen", 64'(b2.seg_pen), 64'd1);
    chk("rst_seg_clk", 64'(b2.seg_clk), 64'd0);
    chk("rst_seg_do",  64'(b2.seg_do),  64'd0);
    chk("rst_done",    64'(b2.done),    64'd0);
    chk("rst_ready",   64'(b2.ready),   64'd0);
    b2.valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_seg_clr", 64'(b2.seg_clr), 64'd1);
    chk("rel_ready",   64'(b2.ready),   64'd1);

    for (int i = 0; i < 5; i++) begin
      run_frame(tv[i].pdata, tv[i].mode, 0, stream, lat, rises, pen_bad, rdy_bad, stab_bad, acc_cyc);
      chk($sformatf("v%0d_stream", i), stream, tv[i].exp_stream);
      chk($sformatf("v%0d_done_lat", i), 64'(lat), 64'(tv[i].exp_lat));
      chk($sformatf("v%0d_rises", i), 64'(rises), 64'(tv[i].exp_rises));
      chk($sformatf("v%0d_pen_shift", i), 64'(pen_bad), 64'd0);
      chk($sformatf("v%0d_ready_shift", i), 64'(rdy_bad), 64'd0);
      chk($sformatf("v%0d_do_stable", i), 64'(stab_bad), 64'd0);
      chk($sformatf("v%0d_done_pen", i), 64'(b2.seg_pen), 64'd1);
      chk($sformatf("v%0d_done_clk", i), 64'(b2.seg_clk), 64'd0);
      chk($sformatf("v%0d_done_do", i), 64'(b2.seg_do), 64'd0);
      if (i == 2) chk("hold_period", 64'(acc_cyc - prev_acc), 64'd258);
      prev_acc = acc_cyc;
      if (!(tv[i].mode == 1 && i + 1 < 5 && tv[i+1].mode == 1)) b2.valid = 1'b0;
    end

    // Ready must fall back to 1 the cycle after done
    @(negedge clk);
    chk("post_done_ready", 64'(b2.ready), 64'd1);

    // Reset during bit 20 aborts the frame at the next edge
    run_frame(64'hDEAD_BEEF_CAFE_F00D, 0, 21, stream, lat, rises, pen_bad, rdy_bad, stab_bad, acc_cyc);
    chk("abort_prefix", 64'(stream[20:0]), 64'({64'hDEAD_BEEF_CAFE_F00D} >> 43));
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_seg_clk", 64'(b2.seg_clk), 64'd0);
    chk("abort_seg_do",  64'(b2.seg_do),  64'd0);
    chk("abort_seg_pen", 64'(b2.seg_pen), 64'd1);
    chk("abort_seg_clr", 64'(b2.seg_clr), 64'd0);
    chk("abort_done",    64'(b2.done),    64'd0);
    chk("abort_ready",   64'(b2.ready),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rel_clr", 64'(b2.seg_clr), 64'd1);
    run_frame(64'hC3C3_0000_FFFF_1234, 0, 0, stream, lat, rises, pen_bad, rdy_bad, stab_bad, acc_cyc);
    chk("after_abort_stream", stream, 64'hC3C3_0000_FFFF_1234);
    chk("after_abort_lat", 64'(lat), 64'd257);
    chk("after_abort_stab", 64'(stab_bad), 64'd0);

    // Minimum divider: seg_clk toggles every cycle of SHIFT
    begin
      int toggle_bad;
      bit busy;
      toggle_bad = 0; rises = 0; lat = 0; stream = '0; busy = 1'b1;
      @(negedge clk);
      chk("div1_ready", 64'(b1.ready), 64'd1);
      b1.pdata = 64'h0123_4567_89AB_CDEF;
      b1.valid = 1'b1;
      while (busy && lat < 1000) begin
        @(negedge clk);
        lat++;
        b1.valid = 1'b0;
        if (b1.done) busy = 1'b0;
        else begin
          if (b1.seg_clk !== 1'((lat % 2) == 0)) toggle_bad++;
          if (b1.seg_clk) begin
            rises++;
            stream = {stream[62:0], b1.seg_do};
          end
        end
      end
      chk("div1_done_lat", 64'(lat), 64'd129);
      chk("div1_rises", 64'(rises), 64'd64);
      chk("div1_toggle", 64'(toggle_bad), 64'd0);
      chk("div1_stream", stream, 64'h0123_4567_89AB_CDEF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
